// File: rtl/sipo_rx_ctrl_if.sv
// rtl/sipo_rx_ctrl_if.sv - shift-enable and byte handshake bundle between sipo_rx_ctrl and its SIPO/consumer
// Signals:
//   sipo_en    controller -> SIPO      one-cycle shift enable
//   sipo_din   controller -> SIPO      bit to shift, valid while sipo_en=1
//   byte_valid controller -> consumer  SIPO dout holds a complete framed byte
//   byte_ready consumer -> controller  byte accepted when byte_valid & byte_ready
// Modports: master = controller side, slave = SIPO/consumer side.
interface sipo_rx_ctrl_if;
    logic sipo_en;
    logic sipo_din;
    logic byte_valid;
    logic byte_ready;

    modport master (
        output sipo_en,
        output sipo_din,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  sipo_en,
        input  sipo_din,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/sipo_rx_ctrl.sv
// rtl/sipo_rx_ctrl.sv - serial frame sequencer driving an 8-bit shift-left SIPO register
// Purpose: frames an async serial line (start 0, 8 data bits MSB first, stop 1),
//   pulses the SIPO shift enable at each data bit centre and offers the finished
//   byte through a valid/ready handshake, flagging framing and overrun errors.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx         asynchronous serial input, idles high
//   sif        sipo_rx_ctrl_if.master (sipo_en, sipo_din, byte_valid, byte_ready)
//   busy       high whenever the FSM is not in IDLE
//   frame_err  one-cycle pulse when the stop bit is sampled 0
//   overrun    sticky, set when a new frame starts shifting over a pending byte
//   ovr_clr    synchronous clear of overrun (a same-cycle set wins)
//   parity_err one-cycle pulse at STOP on parity mismatch (only with SIPO_RX_PARITY_EN)
// Optional feature macro: SIPO_RX_PARITY_EN adds a parity bit between data and stop.
module sipo_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    sipo_rx_ctrl_if.master        sif,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun,
`ifdef SIPO_RX_PARITY_EN
    output logic                  parity_err,
`endif
    input  logic                  ovr_clr
);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic              byte_valid_q, byte_valid_d;
    logic              overrun_q, overrun_d;
    logic              armed_q, armed_d;
    logic              rx_meta_q, rx_s_q;

`ifdef SIPO_RX_PARITY_EN
    logic              par_q, par_d;
    logic              par_err_q, par_err_d;
`endif

    logic              tick;
    logic              shift_c;
    logic              first_shift_c;
    logic              stop_ok_c;
    logic              frame_err_c;
    logic              parity_err_c;
    logic              ovr_set_c;

    // Two-flop synchronizer; flops reset to the idle line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bitcnt_q     <= '0;
            byte_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            armed_q      <= 1'b1;
`ifdef SIPO_RX_PARITY_EN
            par_q        <= 1'b0;
            par_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitcnt_q     <= bitcnt_d;
            byte_valid_q <= byte_valid_d;
            overrun_q    <= overrun_d;
            armed_q      <= armed_d;
`ifdef SIPO_RX_PARITY_EN
            par_q        <= par_d;
            par_err_q    <= par_err_d;
`endif
        end
    end

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bitcnt_d      = bitcnt_q;
        armed_d       = armed_q;
        byte_valid_d  = byte_valid_q;
        overrun_d     = overrun_q;
        shift_c       = 1'b0;
        first_shift_c = 1'b0;
        stop_ok_c     = 1'b0;
        frame_err_c   = 1'b0;
        parity_err_c  = 1'b0;
        ovr_set_c     = 1'b0;
`ifdef SIPO_RX_PARITY_EN
        par_d         = par_q;
        par_err_d     = par_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                // After a break the line must return high before a new start
                // is accepted, so a held-low line yields a single frame_err.
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end
                if (!rx_s_q && armed_q) begin
                    cnt_d   = HALF_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rx_s_q) begin
                        cnt_d    = FULL_LOAD;
                        bitcnt_d = 3'd0;
`ifdef SIPO_RX_PARITY_EN
                        par_d    = 1'b0;
`endif
                        state_d  = S_DATA;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_c       = 1'b1;
                    first_shift_c = (bitcnt_q == 3'd0);
                    bitcnt_d      = bitcnt_q + 3'd1;
                    cnt_d         = FULL_LOAD;
`ifdef SIPO_RX_PARITY_EN
                    par_d         = par_q ^ rx_s_q;
`endif
                    if (bitcnt_q == 3'd7) begin
`ifdef SIPO_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef SIPO_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    // Expected parity bit is 1 when the data holds an even
                    // number of ones; par_q is the XOR of the data bits.
                    par_err_d = rx_s_q ^ ~par_q;
                    cnt_d     = FULL_LOAD;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    if (rx_s_q) begin
`ifdef SIPO_RX_PARITY_EN
                        stop_ok_c = ~par_err_q;
`else
                        stop_ok_c = 1'b1;
`endif
                    end else begin
                        frame_err_c = 1'b1;
                        armed_d     = 1'b0;
                    end
`ifdef SIPO_RX_PARITY_EN
                    parity_err_c = par_err_q;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A handshake takes priority over overrun when it coincides with the
        // first shift of the next frame; otherwise that shift destroys the byte.
        if (byte_valid_q && sif.byte_ready) begin
            byte_valid_d = 1'b0;
        end else if (byte_valid_q && first_shift_c) begin
            byte_valid_d = 1'b0;
            ovr_set_c    = 1'b1;
        end
        if (stop_ok_c) begin
            byte_valid_d = 1'b1;
        end

        if (ovr_set_c) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    assign sif.sipo_en    = shift_c;
    assign sif.sipo_din   = shift_c & rx_s_q;
    assign sif.byte_valid = byte_valid_q;
    assign busy           = (state_q != S_IDLE);
    assign frame_err      = frame_err_c;
    assign overrun        = overrun_q;
`ifdef SIPO_RX_PARITY_EN
    assign parity_err     = parity_err_c;
`else
    logic unused_parity;
    assign unused_parity  = parity_err_c;
`endif

endmodule
